mant_mul_seq: RTL and testbench

MANT_MUL_SEQ -- requirements
Module: mant_mul_seq

---
 rtl/mant_mul_seq_if.sv | 26 ++
 rtl/mant_mul_seq.sv | 89 ++++++++
 tb/tb_mant_mul_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mant_mul_seq_if.sv
// Operand/result handshake bundle for the sequential mantissa multiplier.
// master = producer/consumer side, slave = multiplier side.
interface mant_mul_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-2:0]   mant_out;
  logic               exp_inc;
  logic               unnorm;

  modport master (
    output in_valid, ma, mb, out_ready,
    input  in_ready, out_valid, product, mant_out, exp_inc, unnorm
  );

  modport slave (
    input  in_valid, ma, mb, out_ready,
    output in_ready, out_valid, product, mant_out, exp_inc, unnorm
  );
endinterface

// File: rtl/mant_mul_seq.sv
// Shift-add mantissa multiplier: WIDTH steps per operand pair, then the
// product is normalized (1-bit right shift if needed) and truncated.
module mant_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  mant_mul_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last_step;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-2:0]   mant_r;
  logic               exp_r;
  logic               unnorm_r;

  assign last_step = (cnt == CW'(1));
  assign sum       = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = MUL;
      MUL:     if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are registered on the final MUL step straight from the adder,
  // so they are valid on DONE entry and untouched until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      prod_r   <= '0;
      mant_r   <= '0;
      exp_r    <= 1'b0;
      unnorm_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, bus.ma};
            mplier <= bus.mb;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
          end
        end
        MUL: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (last_step) begin
            prod_r   <= sum;
            mant_r   <= sum[2*WIDTH-1] ? sum[2*WIDTH-2:WIDTH] : sum[2*WIDTH-3:WIDTH-1];
            exp_r    <= sum[2*WIDTH-1];
            unnorm_r <= ~sum[2*WIDTH-1] & ~sum[2*WIDTH-2];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = prod_r;
  assign bus.mant_out  = mant_r;
  assign bus.exp_inc   = exp_r;
  assign bus.unnorm    = unnorm_r;
endmodule

// File: tb/tb_mant_mul_seq.sv
// Scoreboard bench for mant_mul_seq: a driver pushes hand-computed results,
// a monitor compares them whenever the multiplier presents a result.
module tb_mant_mul_seq;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [6:0]  m;
    logic        e;
    logic        u;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic [6:0]  m;
    logic        e;
    logic        u;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_sent   = 0;
  int   n_done   = 0;
  int   ready_mode  = 0;
  logic stall_ready = 1'b1;
  exp_t sbq[$];

  vec_t vecs [12] = '{
    '{8'h80, 8'h80, 16'h4000, 7'h00, 1'b0, 1'b0},
    '{8'hFF, 8'hFF, 16'hFE01, 7'h7E, 1'b1, 1'b0},
    '{8'hC0, 8'hC0, 16'h9000, 7'h10, 1'b1, 1'b0},
    '{8'h01, 8'h01, 16'h0001, 7'h00, 1'b0, 1'b1},
    '{8'hA0, 8'h90, 16'h5A00, 7'h34, 1'b0, 1'b0},
    '{8'h00, 8'hFF, 16'h0000, 7'h00, 1'b0, 1'b1},
    '{8'h81, 8'h83, 16'h4203, 7'h04, 1'b0, 1'b0},
    '{8'hB5, 8'hE7, 16'hA353, 7'h23, 1'b1, 1'b0},
    '{8'h9C, 8'hD2, 16'h7FF8, 7'h7F, 1'b0, 1'b0},
    '{8'hF0, 8'h88, 16'h7F80, 7'h7F, 1'b0, 1'b0},
    '{8'hAB, 8'hCD, 16'h88EF, 7'h08, 1'b1, 1'b0},
    '{8'hC3, 8'hA5, 16'h7DAF, 7'h7B, 1'b0, 1'b0}
  };

  mant_mul_seq_if #(.WIDTH(8)) bus ();

  mant_mul_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = stall_ready;
    endcase
  end

  // Monitor: compares every presented result (including stalled cycles)
  // against the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sbq[0];
        chk("product",  bus.product,  e.p);
        chk("mant_out", bus.mant_out, e.m);
        chk("exp_inc",  bus.exp_inc,  e.e);
        chk("unnorm",   bus.unnorm,   e.u);
        chk("in_ready_in_done", bus.in_ready, 1'b0);
        if (bus.out_ready) begin
          void'(sbq.pop_front());
          n_done++;
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit push, input bit measure);
    int unsigned w = 0;
    int unsigned k = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.ma = v.a;
    bus.mb = v.b;
    if (push) begin
      sbq.push_back('{v.p, v.m, v.e, v.u});
      n_sent++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.ma = v.a ^ 8'h5A;
    bus.mb = ~v.b;
    if (measure) begin
      k = 0;
      while (k < 30) begin
        @(negedge clk);
        k++;
        if (bus.out_valid) break;
      end
      chk("latency", k, 32'd9);
    end
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", sbq.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    bus.in_valid  = 1'b0;
    bus.ma        = '0;
    bus.mb        = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_product",   bus.product,   16'h0);
    chk("rst_mant_out",  bus.mant_out,  7'h0);
    chk("rst_exp_inc",   bus.exp_inc,   1'b0);
    chk("rst_unnorm",    bus.unnorm,    1'b0);
    @(negedge clk);
    rst = 1'b0;

    send(vecs[0], 1'b1, 1'b1);
    send(vecs[1], 1'b1, 1'b0);
    send(vecs[3], 1'b1, 1'b0);
    send(vecs[5], 1'b1, 1'b1);
    drain();

    // Back-pressure: hold the result for 5 cycles, then release.
    ready_mode  = 2;
    stall_ready = 1'b0;
    send(vecs[2], 1'b1, 1'b0);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("stall_out_valid", bus.out_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_out_valid_held", bus.out_valid, 1'b1);
    end
    stall_ready = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("release_in_ready_same", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("release_in_ready_next", bus.in_ready, 1'b1);
    chk("release_out_valid", bus.out_valid, 1'b0);
    ready_mode = 0;

    // Abort mid-MUL: no result may appear for this operand pair.
    send(vecs[1], 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_product",   bus.product,   16'h0);
    chk("abort_mant_out",  bus.mant_out,  7'h0);
    chk("abort_exp_inc",   bus.exp_inc,   1'b0);
    chk("abort_unnorm",    bus.unnorm,    1'b0);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    #1 rst = 1'b0;
    chk("abort_in_ready",  bus.in_ready,  1'b1);
    send(vecs[4], 1'b1, 1'b1);
    drain();

    // Randomized handshake timing over directed operand pairs.
    ready_mode = 1;
    for (int i = 6; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(vecs[i], 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(vecs[(i * 5 + 1) % 12], 1'b1, 1'b0);
    end
    drain();
    ready_mode = 0;
    repeat (20) @(negedge clk);
    chk("results_count", n_done, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
